// File: rtl/pixel_width_converter_pkg.sv
// Shared types and helpers for the burst-to-pixel width converter.
// Holds the frame-lock state encoding, tuser bit positions and counter width helper.
package pixel_stream_pkg;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      RUN      = 2'd1,
      DRAIN    = 2'd2
   } state_e;

   localparam int SOF_BIT = 0;
   localparam int EOL_BIT = 1;

   // Width of a counter/index covering 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pixel_width_converter_if.sv
// AXI-Stream style bundle used for both sides of the width converter.
interface pixel_width_converter_if #(
   parameter int DATA_W = 100,
   parameter int USER_W = 2
);
   logic              tvalid;
   logic              tready;
   logic [DATA_W-1:0] tdata;
   logic [USER_W-1:0] tuser;
   logic              tlast;

   modport master (output tvalid, tdata, tuser, tlast, input tready);
   modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/burst_shift_slot.sv
// Active output slot: holds one burst and shifts it out PIX_OUT pixels at a time.
// Load wins over shift, shift wins over clear.
module burst_shift_slot
   import pixel_stream_pkg::*;
#(
   parameter int PIX_W   = 10,
   parameter int PIX_IN  = 10,
   parameter int PIX_OUT = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     load_i,
   input  logic                     shift_i,
   input  logic                     clear_i,
   input  logic [PIX_W*PIX_IN-1:0]  data_i,
   output logic [PIX_W*PIX_OUT-1:0] data_o,
   output logic                     valid_o,
   output logic                     last_o
);
   localparam int SUB   = PIX_IN / PIX_OUT;
   localparam int IDX_W = cnt_w(SUB);
   localparam int DW    = PIX_W * PIX_IN;

   logic [DW-1:0]    data_q, data_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      if (load_i) begin
         data_d  = data_i;
         idx_d   = '0;
         valid_d = 1'b1;
      end else if (shift_i) begin
         data_d = data_q >> (PIX_W * PIX_OUT);
         idx_d  = idx_q + 1'b1;
      end else if (clear_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q[PIX_W*PIX_OUT-1:0];
   assign valid_o = valid_q;
   assign last_o  = (idx_q == IDX_W'(SUB - 1));

endmodule

// File: rtl/pixel_width_converter.sv
// Splits wide pixel bursts into PIXELS_PER_OUT-pixel beats with a double buffer,
// locking to SOF and generating SOF/EOL/tlast markers and row/column counters.
module pixel_width_converter
   import pixel_stream_pkg::*;
#(
   parameter int PIXEL_BIT_WIDTH  = 10,
   parameter int PIXELS_PER_BURST = 10,
   parameter int PIXELS_PER_OUT   = 1,
   parameter int USER_WIDTH       = 2,
   parameter int IN_ROWS          = 20,
   parameter int IN_COLS          = 20
) (
   input  logic                      clk,
   input  logic                      reset,
   pixel_width_converter_if.slave    s_axis,
   pixel_width_converter_if.master   m_axis,
   output logic [cnt_w(IN_COLS)-1:0] cnt_col,
   output logic [cnt_w(IN_ROWS)-1:0] cnt_row,
   output logic                      frame_err
);
   localparam int DW_IN  = PIXEL_BIT_WIDTH * PIXELS_PER_BURST;
   localparam int BURSTS = IN_ROWS * IN_COLS / PIXELS_PER_BURST;
   localparam int COL_W  = cnt_w(IN_COLS);
   localparam int ROW_W  = cnt_w(IN_ROWS);
   localparam int BC_W   = cnt_w(BURSTS + 1);

   if ((PIXELS_PER_BURST % PIXELS_PER_OUT) != 0) begin : g_chk_out
      $error("PIXELS_PER_OUT must divide PIXELS_PER_BURST");
   end
   if ((IN_COLS % PIXELS_PER_BURST) != 0) begin : g_chk_cols
      $error("IN_COLS must be a multiple of PIXELS_PER_BURST");
   end

   state_e           state_q, state_d;
   logic [DW_IN-1:0] pend_q, pend_d;
   logic             pend_v_q, pend_v_d;
   logic [BC_W-1:0]  bcnt_q, bcnt_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             err_q, err_d;

   logic             act_v, act_last, act_load, act_shift, act_clear;
   logic [DW_IN-1:0] act_data_in;
   logic             s_rdy, s_hs, sof_in, in_data, m_hs, act_last_hs;
   logic             to_act_in, eol, last_beat;
   logic             unused_in;

   // Ready is decoded from state only, so it never depends on m_axis.tready.
   assign s_rdy     = (state_q == WAIT_SOF) || ((state_q == RUN) && !pend_v_q);
   assign s_hs      = s_axis.tvalid && s_rdy;
   assign sof_in    = s_axis.tuser[SOF_BIT];
   assign in_data   = s_hs && ((state_q == RUN) || sof_in);
   assign unused_in = ^{s_axis.tuser, s_axis.tlast};

   assign m_hs        = act_v && m_axis.tready;
   assign act_last_hs = m_hs && act_last;
   assign eol         = (col_q == COL_W'(IN_COLS - PIXELS_PER_OUT));
   assign last_beat   = eol && (row_q == ROW_W'(IN_ROWS - 1));

   // Incoming burst goes straight to ACT when it is empty or is being vacated
   // with nothing waiting in PEND; otherwise it parks in PEND.
   assign to_act_in   = in_data && (!act_v || (act_last_hs && !pend_v_q));
   assign act_load    = to_act_in || (act_last_hs && pend_v_q);
   assign act_data_in = (act_last_hs && pend_v_q) ? pend_q : s_axis.tdata;
   assign act_shift   = m_hs && !act_last;
   assign act_clear   = act_last_hs;

   burst_shift_slot #(
      .PIX_W  (PIXEL_BIT_WIDTH),
      .PIX_IN (PIXELS_PER_BURST),
      .PIX_OUT(PIXELS_PER_OUT)
   ) u_act (
      .clk    (clk),
      .reset  (reset),
      .load_i (act_load),
      .shift_i(act_shift),
      .clear_i(act_clear),
      .data_i (act_data_in),
      .data_o (m_axis.tdata),
      .valid_o(act_v),
      .last_o (act_last)
   );

   always_comb begin
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      if (in_data && !to_act_in) begin
         pend_d   = s_axis.tdata;
         pend_v_d = 1'b1;
      end else if (act_last_hs && pend_v_q) begin
         pend_v_d = 1'b0;
      end

      col_d = col_q;
      row_d = row_q;
      if (m_hs) begin
         if (last_beat) begin
            col_d = '0;
            row_d = '0;
         end else if (eol) begin
            col_d = '0;
            row_d = row_q + 1'b1;
         end else begin
            col_d = col_q + COL_W'(PIXELS_PER_OUT);
         end
      end

      state_d = state_q;
      bcnt_d  = bcnt_q;
      err_d   = 1'b0;
      case (state_q)
         WAIT_SOF: if (s_hs && sof_in) begin
            bcnt_d  = BC_W'(1);
            state_d = (BURSTS == 1) ? DRAIN : RUN;
         end
         RUN: if (s_hs) begin
            bcnt_d = bcnt_q + 1'b1;
            err_d  = sof_in;
            if (bcnt_q == BC_W'(BURSTS - 1)) state_d = DRAIN;
         end
         DRAIN: if (m_hs && last_beat) state_d = WAIT_SOF;
         default: state_d = WAIT_SOF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= WAIT_SOF;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
         bcnt_q   <= '0;
         col_q    <= '0;
         row_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
         bcnt_q   <= bcnt_d;
         col_q    <= col_d;
         row_q    <= row_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      m_axis.tuser          = '0;
      m_axis.tuser[SOF_BIT] = act_v && (col_q == '0) && (row_q == '0);
      m_axis.tuser[EOL_BIT] = act_v && eol;
   end

   assign m_axis.tvalid = act_v;
   assign m_axis.tlast  = act_v && last_beat;
   assign s_axis.tready = s_rdy;
   assign cnt_col       = col_q;
   assign cnt_row       = row_q;
   assign frame_err     = err_q;

endmodule

// File: tb/tb_pixel_width_converter.sv
// Scoreboard bench for pixel_width_converter: one instance with 1-pixel beats,
// one with 5-pixel beats, randomized valid/ready, checked against a raster-order model.
module tb_pixel_width_converter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   pixel_width_converter_if #(.DATA_W(100), .USER_W(2)) s0 ();
   pixel_width_converter_if #(.DATA_W(10),  .USER_W(2)) m0 ();
   pixel_width_converter_if #(.DATA_W(100), .USER_W(2)) s1 ();
   pixel_width_converter_if #(.DATA_W(50),  .USER_W(2)) m1 ();

   logic [4:0] col0, row0, col1, row1;
   logic       err0, err1;

   pixel_width_converter #(.PIXELS_PER_OUT(1)) dut0 (
      .clk(clk), .reset(reset), .s_axis(s0), .m_axis(m0),
      .cnt_col(col0), .cnt_row(row0), .frame_err(err0));

   pixel_width_converter #(.PIXELS_PER_OUT(5)) dut1 (
      .clk(clk), .reset(reset), .s_axis(s1), .m_axis(m1),
      .cnt_col(col1), .cnt_row(row1), .frame_err(err1));

   typedef struct packed {
      logic [49:0] data;
      logic [1:0]  user;
      logic        last;
      logic [4:0]  col;
      logic [4:0]  row;
   } beat_t;

   beat_t o0, o1;
   assign o0 = {40'b0, m0.tdata, m0.tuser, m0.tlast, col0, row0};
   assign o1 = {m1.tdata, m1.tuser, m1.tlast, col1, row1};

   beat_t q0[$], q1[$];
   int    checks = 0, errors = 0;
   int    rdy_pct = 100;
   bit    mon_en = 1'b0;
   int    cyc = 0;
   int    seen[2], first_cyc[2], span[2], err_seen[2], exp_err[2], bidx[2];
   bit    in_frame[2], stall[2], prev_err[2];
   beat_t prev[2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: frame pixels in raster order, beat k carries pixels k*ppo..k*ppo+ppo-1.
   task automatic model(input int d, input logic [99:0] bd, input logic sof);
      int    ppo = (d == 0) ? 1 : 5;
      int    pos;
      beat_t b;
      if (!in_frame[d]) begin
         if (!sof) return;
         in_frame[d] = 1'b1;
         bidx[d] = 0;
      end else if (sof) begin
         exp_err[d]++;
      end
      for (int j = 0; j < 10 / ppo; j++) begin
         pos    = bidx[d] * 10 + j * ppo;
         b.data = 50'(bd >> (j * ppo * 10)) & ((50'd1 << (ppo * 10)) - 50'd1);
         b.user = {((pos + ppo) % 20) == 0, pos == 0};
         b.last = (pos + ppo) == 400;
         b.col  = 5'(pos % 20);
         b.row  = 5'(pos / 20);
         if (d == 0) q0.push_back(b); else q1.push_back(b);
      end
      bidx[d]++;
      if (bidx[d] == 40) in_frame[d] = 1'b0;
   endtask

   task automatic mon(input int d, input beat_t o, input logic v, input logic r, input logic e);
      beat_t x;
      int    qs;
      if (!mon_en || reset) begin
         stall[d]    = 1'b0;
         prev_err[d] = 1'b0;
         return;
      end
      if (stall[d]) check($sformatf("hold%0d", d), {v, o}, {1'b1, prev[d]});
      if (e) begin
         err_seen[d]++;
         check($sformatf("err_width%0d", d), {prev_err[d], e}, 2'b01);
      end
      prev_err[d] = e;
      if (v && r) begin
         qs = (d == 0) ? q0.size() : q1.size();
         if (qs == 0) begin
            checks++;
            errors++;
            $display("FAIL beat%0d: got unexpected beat %0h, expected no output", d, o);
         end else begin
            if (d == 0) x = q0.pop_front(); else x = q1.pop_front();
            check($sformatf("beat%0d_%0d", d, seen[d]), o, x);
         end
         if (o.user[0]) first_cyc[d] = cyc;
         if (o.last) span[d] = cyc - first_cyc[d];
         seen[d]++;
      end
      stall[d] = v && !r;
      prev[d]  = o;
   endtask

   initial forever begin
      @(negedge clk);
      cyc++;
      mon(0, o0, m0.tvalid, m0.tready, err0);
      mon(1, o1, m1.tvalid, m1.tready, err1);
   end

   initial begin
      m0.tready = 1'b0;
      m1.tready = 1'b0;
      forever begin
         @(posedge clk); #1;
         m0.tready = ($urandom_range(99) < rdy_pct);
         m1.tready = ($urandom_range(99) < rdy_pct);
      end
   end

   task automatic send(input int d, input logic [99:0] bd, input logic [1:0] user);
      int   n = 0;
      logic rdy;
      if (d == 0) begin s0.tvalid = 1'b1; s0.tdata = bd; s0.tuser = user; end
      else        begin s1.tvalid = 1'b1; s1.tdata = bd; s1.tuser = user; end
      do begin
         @(negedge clk);
         rdy = (d == 0) ? s0.tready : s1.tready;
         n++;
      end while (!rdy && n < 1000);
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL accept%0d: s_axis_tready stayed 0 for %0d cycles, expected 1", d, n);
      end else begin
         model(d, bd, user[0]);
      end
      @(posedge clk); #1;
      if (d == 0) s0.tvalid = 1'b0; else s1.tvalid = 1'b0;
   endtask

   task automatic send_bursts(input int d, input int nb, input bit gap, input int errb);
      logic [99:0] bd;
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < 10; k++) bd[k*10 +: 10] = 10'(b * 10 + k);
         if (gap) repeat ($urandom_range(2)) begin @(posedge clk); #1; end
         send(d, bd, {1'b0, (b == 0) || (b == errb)});
      end
   endtask

   task automatic wait_empty(input int d);
      int n = 0;
      while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("drain%0d", d), (d == 0) ? q0.size() : q1.size(), 0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
   endtask

   initial begin
      #3_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      int n;
      s0.tvalid = 1'b0; s0.tdata = '0; s0.tuser = '0; s0.tlast = 1'b0;
      s1.tvalid = 1'b0; s1.tdata = '0; s1.tuser = '0; s1.tlast = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", m0.tvalid, 0);
      check("rst_tuser", m0.tuser, 0);
      check("rst_tlast", m0.tlast, 0);
      check("rst_frame_err", err0, 0);
      check("rst_counters", {col0, row0}, 0);
      check("rst_tdata", m0.tdata, 0);
      check("rst_tready", s0.tready, 1);
      check("rst_dut1", {m1.tvalid, m1.tdata, s1.tready}, 1);
      reset   = 1'b0;
      mon_en  = 1'b1;
      @(posedge clk); #1;

      // Junk before SOF, then a gap-free ramp frame.
      repeat (3) send(0, {10{10'd999}}, 2'b00);
      send_bursts(0, 40, 1'b0, -1);
      wait_empty(0);
      check("tput0", span[0], 399);

      // Random stalls on both sides.
      rdy_pct = 50;
      send_bursts(0, 40, 1'b1, -1);
      wait_empty(0);
      rdy_pct = 100;

      // Stray SOF on burst 7.
      send_bursts(0, 40, 1'b0, 7);
      wait_empty(0);
      check("frame_err_count0", err_seen[0], exp_err[0]);
      check("frame_err_expected", exp_err[0], 1);

      // Reset while beat 123 is being presented, then a fresh frame.
      seen[0] = 0;
      send_bursts(0, 13, 1'b0, -1);
      n = 0;
      do begin @(negedge clk); n++; end while (seen[0] < 123 && n < 2000);
      check("reach_beat123", seen[0] >= 123, 1);
      mon_en = 1'b0;
      reset  = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_tvalid", m0.tvalid, 0);
      check("mid_rst_counters", {col0, row0}, 0);
      check("mid_rst_tready", s0.tready, 1);
      q0.delete();
      in_frame[0] = 1'b0;
      bidx[0]     = 0;
      mon_en      = 1'b1;
      @(posedge clk); #1;
      send_bursts(0, 40, 1'b0, -1);
      wait_empty(0);

      // Five pixels per output beat.
      send_bursts(1, 40, 1'b0, -1);
      wait_empty(1);
      check("tput1", span[1], 79);
      rdy_pct = 50;
      send_bursts(1, 40, 1'b1, -1);
      wait_empty(1);

      check("frame_err_final0", err_seen[0], exp_err[0]);
      check("frame_err_final1", err_seen[1], exp_err[1]);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pixel_width_converter.md
# pixel_width_converter

Parametrised burst-to-pixel width converter for the CustomLogic pixel path. It accepts wide multi-pixel bursts on an AXI-Stream slave and emits narrower beats of `PIXELS_PER_OUT` pixels on an AXI-Stream master. A double buffer lets it run at full throughput under backpressure. It locks to start-of-frame, tracks row and column, generates SOF/EOL/tlast markers, and flags frame errors.

## Interface
- `PIXEL_BIT_WIDTH`, 10: bits per pixel.
- `PIXELS_PER_BURST`, 10: pixels per input beat.
- `PIXELS_PER_OUT`, 1: pixels per output beat; must divide `PIXELS_PER_BURST`.
- `USER_WIDTH`, 2: input tuser width; bit0 = SOF.
- `IN_ROWS`, 20: rows per frame.
- `IN_COLS`, 20: columns per frame; must be a multiple of `PIXELS_PER_BURST`.
- Ports:
  - `clk` in 1: clock.
  - `reset` in 1: reset, synchronous, active-high.
  - `s_axis_tvalid` in 1; `s_axis_tready` out 1.
  - `s_axis_tdata` in `PIXEL_BIT_WIDTH*PIXELS_PER_BURST`: pixel 0 in LSBs.
  - `s_axis_tuser` in `USER_WIDTH`: bit0 = first burst of frame.
  - `m_axis_tvalid` out 1; `m_axis_tready` in 1.
  - `m_axis_tdata` out `PIXEL_BIT_WIDTH*PIXELS_PER_OUT`: earliest pixel in LSBs.
  - `m_axis_tuser` out 2: bit0 SOF, bit1 EOL.
  - `m_axis_tlast` out 1: last beat of frame.
  - `cnt_col` out `$clog2(IN_COLS)`: column of the LSB pixel of the current output beat.
  - `cnt_row` out `$clog2(IN_ROWS)`: row of the current output beat.
  - `frame_err` out 1: one-cycle pulse on error.

## Operation
- Derived constants:
  - SUB = `PIXELS_PER_BURST/PIXELS_PER_OUT`
  - BURSTS = `IN_ROWS*IN_COLS/PIXELS_PER_BURST`
  - BEATS = BURSTS*SUB
- Storage has two slots:
  - ACT: a shift slot with a sub-beat index of 0..SUB-1 and a valid flag. It drives `m_axis_tdata` from its low `PIXELS_PER_OUT` pixels.
  - PEND: a holding register with a valid flag.
- State machine:
  - WAIT_SOF: `s_axis_tready`=1. Beats with tuser[0]=0 are dropped. A beat with tuser[0]=1 loads ACT and sets the input burst count to 1. Next state is RUN, or DRAIN if BURSTS==1.
  - RUN: `s_axis_tready`=!PEND.valid. When the accepted burst is number BURSTS, go to DRAIN.
  - DRAIN: `s_axis_tready`=0. The output handshake with `m_axis_tlast`=1 returns to WAIT_SOF.
- Slot update on output handshake:
  - If the sub-beat index < SUB-1, shift ACT by `PIXELS_PER_OUT` pixels and increment the index.
  - If the sub-beat index == SUB-1, load ACT from PEND if PEND is valid; otherwise from the same-cycle input handshake (bypass); otherwise clear ACT.valid.
- An input handshake not consumed by that bypass goes to ACT if ACT is empty, else to PEND.
- `s_axis_tready` is purely registered state; there is no combinational path from `m_axis_tready`.
- Markers:
  - SOF: output beat 0.
  - EOL: the beat whose last pixel is column `IN_COLS-1`.
  - tlast: beat BEATS-1.
- `cnt_col` advances by `PIXELS_PER_OUT` per output handshake and wraps to 0 after the EOL beat; `cnt_row` increments on the EOL beat. Both wrap to 0 after tlast.
- `frame_err` pulses for one cycle when a RUN-state input beat has tuser[0]=1. That beat is processed as ordinary data; there is no resync.
- Elaboration error on a divisibility violation of either parameter constraint.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tuser`, `m_axis_tlast`, `frame_err`, `cnt_col`, `cnt_row` = 0.
  - `m_axis_tdata` = 0.
  - `s_axis_tready` = 1, since the reset state is WAIT_SOF.
- Latency: `m_axis_tvalid` rises 1 cycle after an input handshake into an empty ACT.
- Throughput: one output beat per cycle sustained for any SUB ≥ 1 while the input keeps up.
- While `m_axis_tvalid` && !`m_axis_tready`, the outputs `m_axis_tdata`, `m_axis_tuser`, `m_axis_tlast`, `cnt_col`, `cnt_row` hold stable.
- Reset mid-frame: the next cycle is WAIT_SOF with both slots empty, `m_axis_tvalid`=0 and counters at 0. Partial data is discarded.
- An input handshake and the final output handshake in the same cycle: the bypass load is lossless.

## Structure
- `pixel_stream_pkg`:
  - state enum (WAIT_SOF, RUN, DRAIN);
  - tuser bit indices SOF_BIT=0, EOL_BIT=1;
  - width helper functions.
- Sub-module `burst_shift_slot`: parallel load, shift by `PIXELS_PER_OUT` pixels, sub-beat index, valid flag. It is used for ACT; PEND is a plain register.

## Test plan
- Default params, ramp frame (pixel n = n), both valid/ready held at 1:
  - 400 beats with data 0..399 and no gaps after the first;
  - tuser[1] on beats 19, 39, …, 399;
  - tlast only on beat 399;
  - `cnt_row`/`cnt_col` match n/20 and n%20.
- Three junk bursts (all pixels 999, tuser=0) before SOF: all dropped, first output beat = 0.
- Random 50% `m_axis_tready` and `s_axis_tvalid`: same 0..399 sequence, data stable during every stall, none lost or duplicated.
- `PIXELS_PER_OUT`=5: 80 beats; beat 0 = {4,3,2,1,0}; EOL on beats 3, 7, …; tlast on beat 79.
- tuser[0]=1 on burst 7 mid-frame: `frame_err` high exactly one cycle, output sequence unaffected.
- `reset` pulsed at output beat 123, then a fresh ramp frame: the cycle after reset has tvalid=0 and counters=0, and the new frame outputs 0..399 cleanly.
